// File: rtl/vote_session_ctrl_if.sv
// Purpose: voter-side bundle of the vote session controller: raw switches/buttons in, ballot/status out.
// Latency: none, this is wiring only.
// Backpressure: none, buttons are level inputs and the outputs are held status.
interface vote_session_ctrl_if;
  logic [4:0] sw;
  logic [4:0] btn_vote;
  logic       btn_start;
  logic       btn_close;
  logic [4:0] ballot;
  logic [4:0] cast;
  logic [2:0] n_cast;
  logic       session_open;
  logic       result_valid;

  // Board / stimulus side: drives the raw inputs and observes the session status.
  modport master (
    output sw, btn_vote, btn_start, btn_close,
    input  ballot, cast, n_cast, session_open, result_valid
  );

  // Controller side.
  modport slave (
    input  sw, btn_vote, btn_start, btn_close,
    output ballot, cast, n_cast, session_open, result_valid
  );
endinterface

// File: rtl/vote_session_ctrl.sv
// Purpose: synchronise and debounce the voter/start/close buttons, run the session FSM, and latch one vote per voter.
// Latency: a raw press changes the registered outputs DEB_CYCLES+3 clock edges after it is first sampled high.
// Backpressure: none; presses that the current state cannot use are dropped.
module vote_session_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic               clk,
  input  logic               rst,
  vote_session_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OPEN   = 2'b01,
    CLOSED = 2'b10,
    BAD    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Button vector layout: [4:0] voters, [5] start, [6] close.
  logic [6:0]       btn_raw;
  logic [6:0]       btn_meta;
  logic [6:0]       btn_sync;
  logic [6:0]       db;
  logic [6:0]       db_q;
  logic [6:0]       press;
  logic [CNT_W-1:0] cnt [7];

  logic [4:0] sw_meta;
  logic [4:0] sw_sync;

  logic [4:0] vote_p;
  logic       start_p;
  logic       close_p;

  state_t     state_q, state_n;
  logic [4:0] ballot_q, ballot_n;
  logic [4:0] cast_q, cast_n;
  logic [4:0] cast_new;

  assign btn_raw = {bus.btn_close, bus.btn_start, bus.btn_vote};

  // Two-flop synchronisers for every raw input; switches are only synchronised, not debounced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      sw_meta  <= bus.sw;
      sw_sync  <= sw_meta;
    end
  end

  // Accept a new button level only after it has differed from the held level for DEB_CYCLES cycles in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 7; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (btn_sync[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= btn_sync[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Delayed debounced level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) db_q <= '0;
    else     db_q <= db;
  end

  // One-cycle pulse on each debounced press; releases are not reported.
  assign press   = db & ~db_q;
  assign vote_p  = press[4:0];
  assign start_p = press[5];
  assign close_p = press[6];

  // A voter's first press in a session is the only one that counts.
  assign cast_new = cast_q | vote_p;

  // Session state and latched votes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ballot_q <= '0;
      cast_q   <= '0;
    end else begin
      state_q  <= state_n;
      ballot_q <= ballot_n;
      cast_q   <= cast_n;
    end
  end

  // Next-state and vote-latch logic; close outranks start while a session is open.
  always_comb begin
    state_n  = state_q;
    ballot_n = ballot_q;
    cast_n   = cast_q;
    case (state_q)
      IDLE: begin
        if (start_p) state_n = OPEN;
      end
      OPEN: begin
        ballot_n = ballot_q | (vote_p & ~cast_q & sw_sync);
        cast_n   = cast_new;
        if (close_p || (cast_new == 5'b11111)) state_n = CLOSED;
      end
      CLOSED: begin
        if (start_p) begin
          state_n  = OPEN;
          ballot_n = '0;
          cast_n   = '0;
        end
      end
      default: begin
        state_n  = IDLE;
        ballot_n = '0;
        cast_n   = '0;
      end
    endcase
  end

  assign bus.ballot       = ballot_q;
  assign bus.cast         = cast_q;
  assign bus.n_cast       = 3'(cast_q[0]) + 3'(cast_q[1]) + 3'(cast_q[2]) + 3'(cast_q[3]) + 3'(cast_q[4]);
  assign bus.session_open = (state_q == OPEN);
  assign bus.result_valid = (state_q == CLOSED);

endmodule
